ibex_fetch_req_ctrl: RTL and testbench



---
 rtl/ibex_fetch_req_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-bus fetch request sequencer: word-aligned requests, outstanding tracking, branch discard.
// Optional IBEX_FETCH_ERR_STOP_EN: a committed bus error halts new requests until the next branch.
module ibex_fetch_req_ctrl #(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         addr_i,
   output logic                busy_o,
   output logic                fifo_clear_o,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   input  logic                instr_gnt_i,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i
);

   localparam int unsigned     CNT_W   = $clog2(NUM_REQS + 1);
   localparam logic [CNT_W:0]  MAX_CNT = (CNT_W+1)'(NUM_REQS);

   typedef enum logic [0:0] {IDLE, WAIT_GNT} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_REQS-1:0]   disc_q, disc_d;
   logic [31:0]           fetch_addr_q;
   logic [31:0]           held_addr_q;
   logic [31:0]           branch_addr_q;
   logic                  branch_pend_q;
   logic                  pending_discard_q;

   logic [31:0]           branch_tgt;
   logic [31:0]           issue_addr;
   logic [CNT_W:0]        occ;
   logic                  slot_free;
   logic                  can_issue;
   logic                  err_stop;
   logic                  gnt_fire;
   logic                  pop;
   logic                  push_disc;
   logic [CNT_W-1:0]      wr_idx;

   function automatic logic [CNT_W:0] popcount(input logic [NUM_REQS-1:0] v);
      logic [CNT_W:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         n = n + (CNT_W+1)'(v[i]);
      end
      return n;
   endfunction

   // Issue decision: a pending redirect skips the FIFO occupancy check
   always_comb begin
      branch_tgt = {addr_i[31:2], 2'b00};
      occ        = popcount(fifo_busy_i) + {1'b0, cnt_q};
      if (branch_i || branch_pend_q) begin
         slot_free = ({1'b0, cnt_q} < MAX_CNT);
      end else begin
         slot_free = (occ < MAX_CNT);
      end
      can_issue  = (req_i | branch_i | branch_pend_q) & slot_free & ~err_stop;
      issue_addr = branch_i      ? branch_tgt    :
                   branch_pend_q ? branch_addr_q : fetch_addr_q;
   end

   always_comb begin
      state_d      = state_q;
      instr_req_o  = 1'b0;
      instr_addr_o = issue_addr;
      case (state_q)
         IDLE: begin
            instr_req_o = can_issue;
            if (can_issue && !instr_gnt_i) state_d = WAIT_GNT;
         end
         WAIT_GNT: begin
            instr_req_o  = 1'b1;
            instr_addr_o = held_addr_q;
            if (instr_gnt_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outstanding tracker: bit 0 holds the discard flag of the oldest response
   always_comb begin
      gnt_fire  = instr_req_o & instr_gnt_i;
      pop       = instr_rvalid_i & (cnt_q != '0);
      push_disc = (state_q == WAIT_GNT) & (pending_discard_q | branch_i);
      disc_d    = disc_q | {NUM_REQS{branch_i}};
      if (pop) disc_d = disc_d >> 1;
      wr_idx    = cnt_q - CNT_W'(pop);
      if (gnt_fire) begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (CNT_W'(i) == wr_idx) disc_d[i] = push_disc;
         end
      end
      cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(gnt_fire);
   end

   assign fifo_valid_o = pop & ~disc_q[0] & ~branch_i;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign fifo_addr_o  = addr_i;
   assign fifo_clear_o = branch_i;
   assign busy_o       = instr_req_o | (cnt_q != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         disc_q            <= '0;
         fetch_addr_q      <= '0;
         branch_pend_q     <= 1'b0;
         pending_discard_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         disc_q  <= disc_d;
         if (gnt_fire) fetch_addr_q <= instr_addr_o + 32'd4;
         // A redirect during WAIT_GNT lets the stale request finish, then reissues the target
         if (state_q == WAIT_GNT) begin
            if (branch_i) branch_pend_q <= 1'b1;
            if (instr_gnt_i)   pending_discard_q <= 1'b0;
            else if (branch_i) pending_discard_q <= 1'b1;
         end else begin
            if (can_issue)     branch_pend_q <= 1'b0;
            else if (branch_i) branch_pend_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && can_issue) held_addr_q <= issue_addr;
      if (branch_i) branch_addr_q <= branch_tgt;
   end

`ifdef IBEX_FETCH_ERR_STOP_EN
   logic err_stop_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_stop_q <= 1'b0;
      end else if (branch_i) begin
         err_stop_q <= 1'b0;
      end else if (fifo_valid_o && instr_err_i) begin
         err_stop_q <= 1'b1;
      end
   end

   assign err_stop = err_stop_q & ~branch_i;
`else
   assign err_stop = 1'b0;
`endif

   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      {1'b0, cnt_q} <= MAX_CNT);
   a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (instr_req_o && !instr_gnt_i) |=> $stable(instr_addr_o));
   a_fifo_room: assert property (@(posedge clk_i) disable iff (rst_i)
      fifo_valid_o |-> !(&fifo_busy_i));
   a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      instr_rvalid_i |-> (cnt_q != '0));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scoreboard bench for ibex_fetch_req_ctrl: directed bus vectors, grant/response monitor.
module tb_ibex_fetch_req_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        busy_o;
   logic        fifo_clear_o;
   logic [1:0]  fifo_busy_i = '0;
   logic        fifo_valid_o;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_err_o;
   logic        instr_req_o;
   logic        instr_gnt_i = 1'b0;
   logic [31:0] instr_addr_o;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_addr_q[$];
   logic [33:0] exp_rsp_q[$];

   ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
      .busy_o(busy_o), .fifo_clear_o(fifo_clear_o), .fifo_busy_i(fifo_busy_i),
      .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
      .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
      .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every grant and every response is matched against the scoreboard
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (instr_req_o && instr_gnt_i) begin
            if (exp_addr_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL grant_unexpected: got addr 0x%0h expected no grant", instr_addr_o);
            end else begin
               chk("grant_addr", 64'(instr_addr_o), 64'(exp_addr_q.pop_front()));
            end
         end
         if (instr_rvalid_i) begin
            if (exp_rsp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected: got valid=%0b expected no response", fifo_valid_o);
            end else begin
               chk("rsp_valid_data_err", 64'({fifo_valid_o, fifo_rdata_o, fifo_err_o}),
                   64'(exp_rsp_q.pop_front()));
            end
         end
      end
   end

   task automatic drive(input logic req, input logic br, input logic [31:0] a,
                        input logic [1:0] fb, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic er);
      req_i = req; branch_i = br; addr_i = a; fifo_busy_i = fb;
      instr_gnt_i = gnt; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
      #2;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic exp_grant(input logic [31:0] a);
      exp_addr_q.push_back(a);
   endtask

   task automatic exp_rsp(input logic v, input logic [31:0] d, input logic e);
      exp_rsp_q.push_back({v, d, e});
   endtask

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("reset_req", 64'(instr_req_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_fifo_valid", 64'(fifo_valid_o), 64'd0);
      tick();

      // 1: sequential fetch from 0x100
      exp_grant(32'h100);
      drive(1, 1, 32'h100, 2'b00, 1, 0, 0, 0); tick();
      exp_grant(32'h104); exp_rsp(1, 32'hD000_0100, 0);
      drive(1, 0, 0, 2'b00, 1, 1, 32'hD000_0100, 0); tick();
      exp_grant(32'h108); exp_rsp(1, 32'hD000_0104, 0);
      drive(1, 0, 0, 2'b00, 1, 1, 32'hD000_0104, 0); tick();
      exp_rsp(1, 32'hD000_0108, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0108, 0);
      chk("seq_idle_req", 64'(instr_req_o), 64'd0);
      tick();

      // 2: backpressure from FIFO occupancy
      drive(1, 0, 0, 2'b11, 0, 0, 0, 0);
      chk("bp_full_req", 64'(instr_req_o), 64'd0);
      tick();
      exp_grant(32'h10C);
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 2'b01, 0, 0, 0, 0);
      chk("bp_one_busy_req", 64'(instr_req_o), 64'd0);
      chk("bp_busy_o", 64'(busy_o), 64'd1);
      tick();
      exp_grant(32'h110);
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0);
      chk("bp_drain_req", 64'(instr_req_o), 64'd1);
      tick();
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0);
      chk("bp_two_out_req", 64'(instr_req_o), 64'd0);
      tick();
      exp_rsp(1, 32'hD000_010C, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_010C, 0); tick();
      exp_rsp(1, 32'hD000_0110, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0110, 0); tick();

      // 3: branch while a request waits for grant
      drive(1, 1, 32'h200, 2'b00, 0, 0, 0, 0);
      chk("wg_first_addr", 64'(instr_addr_o), 64'h200);
      tick();
      drive(1, 1, 32'h402, 2'b00, 0, 0, 0, 0);
      chk("wg_branch_addr_held", 64'(instr_addr_o), 64'h200);
      chk("wg_fifo_clear", 64'(fifo_clear_o), 64'd1);
      chk("wg_fifo_addr", 64'(fifo_addr_o), 64'h402);
      tick();
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("wg_req_kept", 64'({instr_req_o, instr_addr_o}), 64'h1_0000_0200);
      chk("wg_no_clear", 64'(fifo_clear_o), 64'd0);
      tick();
      exp_grant(32'h200);
      drive(0, 0, 0, 2'b00, 1, 0, 0, 0); tick();
      exp_grant(32'h400); exp_rsp(0, 32'hD000_0200, 0);
      drive(0, 0, 0, 2'b00, 1, 1, 32'hD000_0200, 0); tick();
      exp_rsp(1, 32'hD000_0400, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0400, 0); tick();

      // 4: branch with two outstanding, landing with the first response
      exp_grant(32'h600);
      drive(1, 1, 32'h600, 2'b00, 1, 0, 0, 0); tick();
      exp_grant(32'h604);
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0); tick();
      exp_rsp(0, 32'hD000_0600, 0);
      drive(1, 1, 32'h80, 2'b00, 0, 1, 32'hD000_0600, 0);
      chk("b2_fifo_clear", 64'(fifo_clear_o), 64'd1);
      chk("b2_no_req_full", 64'(instr_req_o), 64'd0);
      tick();
      exp_grant(32'h80); exp_rsp(0, 32'hD000_0604, 0);
      drive(1, 0, 0, 2'b00, 1, 1, 32'hD000_0604, 0); tick();
      exp_rsp(1, 32'hD000_0080, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0080, 0); tick();

      // 5: address wrap
      exp_grant(32'hFFFF_FFFC);
      drive(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 0, 0); tick();
      exp_grant(32'h0000_0000); exp_rsp(1, 32'hDEAD_BEEF, 0);
      drive(1, 0, 0, 2'b00, 1, 1, 32'hDEAD_BEEF, 0); tick();
      exp_rsp(1, 32'hCAFE_0000, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hCAFE_0000, 0); tick();

      // 6: bus error response
      exp_grant(32'h300);
      drive(1, 1, 32'h300, 2'b00, 1, 0, 0, 0); tick();
      exp_rsp(1, 32'hD000_0300, 1);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0300, 1); tick();
`ifdef IBEX_FETCH_ERR_STOP_EN
      drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("err_stop_req", 64'(instr_req_o), 64'd0);
      tick();
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0);
      chk("err_stop_req2", 64'(instr_req_o), 64'd0);
      tick();
`else
      exp_grant(32'h304);
      drive(1, 0, 0, 2'b00, 1, 0, 0, 0);
      chk("err_cont_req", 64'({instr_req_o, instr_addr_o}), 64'h1_0000_0304);
      tick();
      exp_rsp(1, 32'hD000_0304, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0304, 0); tick();
`endif
      exp_grant(32'h500);
      drive(1, 1, 32'h500, 2'b00, 1, 0, 0, 0);
      chk("err_branch_req", 64'({instr_req_o, instr_addr_o}), 64'h1_0000_0500);
      tick();
      exp_rsp(1, 32'hD000_0500, 0);
      drive(0, 0, 0, 2'b00, 0, 1, 32'hD000_0500, 0); tick();

      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("end_busy", 64'(busy_o), 64'd0);
      chk("end_grants_left", 64'(exp_addr_q.size()), 64'd0);
      chk("end_rsps_left", 64'(exp_rsp_q.size()), 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
